// File: rtl/systolic_seq_ctrl_if.sv
// Host/grid-side signal bundle for the systolic job sequencer.
// Latency: n/a (wires only).
// Backpressure: none; the sequencer is free-running once a job is accepted.
//
// Modports:
//   master : host/command side, drives i_* and observes o_*
//   slave  : sequencer side, observes i_* and drives o_*
// Optional: SYSCTRL_PERF_EN adds o_perf_cycles (32 bits).
interface systolic_seq_ctrl_if #(
    parameter int ROWS  = 9,
    parameter int VEC_W = 16
);
    localparam int WA_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic             i_start;
    logic             i_reuse_w;
    logic [VEC_W-1:0] i_num_vec;
    logic             i_abort;
    logic             o_busy;
    logic             o_done;
    logic             o_wt_rd_en;
    logic [WA_W-1:0]  o_wt_addr;
    logic             o_grid_sel;
    logic             o_act_rd_en;
    logic [VEC_W-1:0] o_act_addr;
    logic             o_res_valid;
    logic [VEC_W-1:0] o_res_idx;
    logic             o_w_valid;
`ifdef SYSCTRL_PERF_EN
    logic [31:0]      o_perf_cycles;

    modport master (
        output i_start, i_reuse_w, i_num_vec, i_abort,
        input  o_busy, o_done, o_wt_rd_en, o_wt_addr, o_grid_sel, o_act_rd_en,
               o_act_addr, o_res_valid, o_res_idx, o_w_valid, o_perf_cycles
    );
    modport slave (
        input  i_start, i_reuse_w, i_num_vec, i_abort,
        output o_busy, o_done, o_wt_rd_en, o_wt_addr, o_grid_sel, o_act_rd_en,
               o_act_addr, o_res_valid, o_res_idx, o_w_valid, o_perf_cycles
    );
`else
    modport master (
        output i_start, i_reuse_w, i_num_vec, i_abort,
        input  o_busy, o_done, o_wt_rd_en, o_wt_addr, o_grid_sel, o_act_rd_en,
               o_act_addr, o_res_valid, o_res_idx, o_w_valid
    );
    modport slave (
        input  i_start, i_reuse_w, i_num_vec, i_abort,
        output o_busy, o_done, o_wt_rd_en, o_wt_addr, o_grid_sel, o_act_rd_en,
               o_act_addr, o_res_valid, o_res_idx, o_w_valid
    );
`endif
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for a ROWSxCOLS weight-stationary PE grid: weight preload, activation feed, result window.
// Latency: all outputs registered; first weight read the cycle after job accept, results RES_LAT after first feed.
// Backpressure: none; i_start is ignored while busy, i_abort returns to IDLE on the next edge.
//
// Ports: i_clk, i_rst (async, active-high) plus interface bus (slave modport):
//   i_start/i_reuse_w/i_num_vec job request, i_abort; o_busy/o_done status; o_wt_rd_en/o_wt_addr weight reads;
//   o_grid_sel load/compute select; o_act_rd_en/o_act_addr activation reads; o_res_valid/o_res_idx result window;
//   o_w_valid complete weight set present.
// Optional: SYSCTRL_PERF_EN adds o_perf_cycles, busy-cycle count of the current/last job.
module systolic_seq_ctrl #(
    parameter int ROWS    = 9,
    parameter int COLS    = 32,
    parameter int VEC_W   = 16,
    parameter int RES_LAT = ROWS + COLS - 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    systolic_seq_ctrl_if.slave   bus
);
    localparam int WA_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int LC_W  = $clog2(ROWS + 1);
    localparam int LAT_W = $clog2(RES_LAT + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [VEC_W-1:0] n_q, n_d;
    logic [LC_W-1:0]  ld_cnt_q, ld_cnt_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [VEC_W-1:0] res_cnt_q, res_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wt_rd_en_q, wt_rd_en_d;
    logic [WA_W-1:0]  wt_addr_q, wt_addr_d;
    logic             grid_sel_q, grid_sel_d;
    logic             act_rd_en_q, act_rd_en_d;
    logic [VEC_W-1:0] act_addr_q, act_addr_d;
    logic             res_valid_q, res_valid_d;
    logic [VEC_W-1:0] res_idx_q, res_idx_d;
    logic             w_valid_q, w_valid_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            ld_cnt_q    <= '0;
            lat_cnt_q   <= '0;
            res_cnt_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wt_rd_en_q  <= 1'b0;
            wt_addr_q   <= '0;
            grid_sel_q  <= 1'b0;
            act_rd_en_q <= 1'b0;
            act_addr_q  <= '0;
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
            w_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            ld_cnt_q    <= ld_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            res_cnt_q   <= res_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wt_rd_en_q  <= wt_rd_en_d;
            wt_addr_q   <= wt_addr_d;
            grid_sel_q  <= grid_sel_d;
            act_rd_en_q <= act_rd_en_d;
            act_addr_q  <= act_addr_d;
            res_valid_q <= res_valid_d;
            res_idx_q   <= res_idx_d;
            w_valid_q   <= w_valid_d;
        end
    end

    // Outputs are computed one cycle ahead so every output comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        ld_cnt_d    = ld_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        res_cnt_d   = res_cnt_q;
        done_d      = 1'b0;
        wt_rd_en_d  = 1'b0;
        wt_addr_d   = wt_addr_q;
        grid_sel_d  = 1'b0;
        act_rd_en_d = 1'b0;
        act_addr_d  = act_addr_q;
        res_valid_d = 1'b0;
        res_idx_d   = res_idx_q;
        w_valid_d   = w_valid_q;

        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    n_d       = bus.i_num_vec;
                    lat_cnt_d = '0;
                    res_cnt_d = '0;
                    if (bus.i_reuse_w && w_valid_q) begin
                        if (bus.i_num_vec == '0) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d     = S_FEED;
                            act_rd_en_d = 1'b1;
                            act_addr_d  = '0;
                        end
                    end else begin
                        // Bottom row first: rows shift south through the grid.
                        state_d    = S_LOAD_W;
                        ld_cnt_d   = '0;
                        wt_rd_en_d = 1'b1;
                        wt_addr_d  = WA_W'(ROWS - 1);
                    end
                end
            end
            S_LOAD_W: begin
                // Select follows the read enable by the one-cycle buffer latency.
                grid_sel_d = wt_rd_en_q;
                if (ld_cnt_q == LC_W'(ROWS)) begin
                    w_valid_d = 1'b1;
                    if (n_q == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = S_FEED;
                        act_rd_en_d = 1'b1;
                        act_addr_d  = '0;
                    end
                end else begin
                    ld_cnt_d = ld_cnt_q + LC_W'(1);
                    if (ld_cnt_q < LC_W'(ROWS - 1)) begin
                        wt_rd_en_d = 1'b1;
                        wt_addr_d  = wt_addr_q - WA_W'(1);
                    end
                end
            end
            S_FEED, S_DRAIN: begin
                // lat_cnt counts cycles since the first feed, saturating once the
                // pipeline latency is covered; the window then emits n_q results.
                if (lat_cnt_q != LAT_W'(RES_LAT))
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                if (lat_cnt_q >= LAT_W'(RES_LAT - 1) && res_cnt_q != n_q) begin
                    res_valid_d = 1'b1;
                    res_idx_d   = res_cnt_q;
                    res_cnt_d   = res_cnt_q + VEC_W'(1);
                end
                if (state_q == S_FEED) begin
                    if (act_addr_q == n_q - VEC_W'(1)) begin
                        state_d = S_DRAIN;
                    end else begin
                        act_rd_en_d = 1'b1;
                        act_addr_d  = act_addr_q + VEC_W'(1);
                    end
                end else if (res_valid_q && res_cnt_q == n_q) begin
                    // The last result is never inside FEED since RES_LAT >= 1.
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.i_abort && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            done_d      = 1'b0;
            wt_rd_en_d  = 1'b0;
            grid_sel_d  = 1'b0;
            act_rd_en_d = 1'b0;
            res_valid_d = 1'b0;
            res_idx_d   = res_idx_q;
            // A partially shifted weight set is unusable.
            if (state_q == S_LOAD_W)
                w_valid_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.o_wt_rd_en  = wt_rd_en_q;
    assign bus.o_wt_addr   = wt_addr_q;
    assign bus.o_grid_sel  = grid_sel_q;
    assign bus.o_act_rd_en = act_rd_en_q;
    assign bus.o_act_addr  = act_addr_q;
    assign bus.o_res_valid = res_valid_q;
    assign bus.o_res_idx   = res_idx_q;
    assign bus.o_w_valid   = w_valid_q;

`ifdef SYSCTRL_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Each busy cycle is credited at the edge that ends it, so the count is
    // final (and then frozen) in the first IDLE cycle after the job.
    always_comb begin
        perf_d = perf_q;
        if (state_q == S_IDLE && bus.i_start)
            perf_d = '0;
        else if (busy_q && perf_q != '1)
            perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) perf_q <= '0;
        else       perf_q <= perf_d;
    end

    assign bus.o_perf_cycles = perf_q;
`endif
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
module tb_systolic_seq_ctrl;
    localparam int ROWS    = 9;
    localparam int COLS    = 32;
    localparam int VEC_W   = 16;
    localparam int RES_LAT = ROWS + COLS - 1;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    systolic_seq_ctrl_if #(.ROWS(ROWS), .VEC_W(VEC_W)) bus ();

    systolic_seq_ctrl #(.ROWS(ROWS), .COLS(COLS), .VEC_W(VEC_W)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cur_k    = 0;
    bit wv_m     = 1'b0;   // model of "grid holds a complete weight set"

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (t=%0t k=%0d): got %0d, want %0d", tag, $time, cur_k, act, exp);
        end
    endtask

    task automatic check_idle(input string tag, input bit all_zero);
        chk({tag, ".busy"},      32'(bus.o_busy),      0);
        chk({tag, ".done"},      32'(bus.o_done),      0);
        chk({tag, ".wt_rd_en"},  32'(bus.o_wt_rd_en),  0);
        chk({tag, ".grid_sel"},  32'(bus.o_grid_sel),  0);
        chk({tag, ".act_rd_en"}, 32'(bus.o_act_rd_en), 0);
        chk({tag, ".res_valid"}, 32'(bus.o_res_valid), 0);
        chk({tag, ".w_valid"},   32'(bus.o_w_valid),   32'(wv_m));
        if (all_zero) begin
            chk({tag, ".wt_addr"},  32'(bus.o_wt_addr),  0);
            chk({tag, ".act_addr"}, 32'(bus.o_act_addr), 0);
            chk({tag, ".res_idx"},  32'(bus.o_res_idx),  0);
`ifdef SYSCTRL_PERF_EN
            chk({tag, ".perf"},     bus.o_perf_cycles,   0);
`endif
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.i_abort = 1'($urandom_range(0, 1));   // abort in IDLE must do nothing
            @(negedge i_clk);
            bus.i_abort = 1'b0;
            cur_k = 0;
            check_idle("idle", 1'b0);
        end
    endtask

    // One job, checked cycle by cycle against the timing rules. k counts the
    // cycles after the accepting edge (k=1 is the first job cycle).
    // abort_at/spur_at: 0 = none, -1 = random, >0 = that cycle. rst_at: 0 = none.
    task automatic run_job(input int n, input bit reuse, input int abort_at_i,
                           input int spur_at_i, input int rst_at);
        bit load;
        int L, f, D, last, abort_at, spur_at;
        bit did_rst;
        load = !(reuse && wv_m);
        L    = load ? ROWS + 1 : 0;
        f    = L + 1;
        D    = (n > 0) ? f + RES_LAT + n : L + 1;
        abort_at = (abort_at_i < 0) ? int'($urandom_range(1, D)) : abort_at_i;
        spur_at  = (spur_at_i < 0 && D > 1) ? int'($urandom_range(1, D - 1)) :
                   (spur_at_i > 0 ? spur_at_i : 0);
        last    = (abort_at > 0 && abort_at <= D) ? abort_at : D;
        did_rst = 1'b0;

        bus.i_start   = 1'b1;
        bus.i_num_vec = VEC_W'(n);
        bus.i_reuse_w = reuse;
        bus.i_abort   = 1'($urandom_range(0, 1));   // start wins over abort in IDLE
        @(negedge i_clk);
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;

        for (int k = 1; k <= last; k++) begin
            bit exp_wt, exp_act, exp_res, exp_wv;
            cur_k   = k;
            exp_wt  = load && k <= ROWS;
            exp_act = (n > 0) && k >= f && k < f + n;
            exp_res = (n > 0) && k >= f + RES_LAT && k < f + RES_LAT + n;
            exp_wv  = (load && k > L) ? 1'b1 : wv_m;
            chk("busy",      32'(bus.o_busy),      1);
            chk("done",      32'(bus.o_done),      32'(k == D));
            chk("wt_rd_en",  32'(bus.o_wt_rd_en),  32'(exp_wt));
            if (exp_wt) chk("wt_addr", 32'(bus.o_wt_addr), 32'(ROWS - k));
            chk("grid_sel",  32'(bus.o_grid_sel),  32'(load && k >= 2 && k <= ROWS + 1));
            chk("act_rd_en", 32'(bus.o_act_rd_en), 32'(exp_act));
            if (exp_act) chk("act_addr", 32'(bus.o_act_addr), 32'(k - f));
            chk("res_valid", 32'(bus.o_res_valid), 32'(exp_res));
            if (exp_res) chk("res_idx", 32'(bus.o_res_idx), 32'(k - f - RES_LAT));
            chk("w_valid",   32'(bus.o_w_valid),   32'(exp_wv));

            if (k == rst_at) begin
                #2 i_rst = 1'b1;
                #1 wv_m = 1'b0;
                check_idle("rst", 1'b1);
                @(negedge i_clk);
                i_rst   = 1'b0;
                did_rst = 1'b1;
                break;
            end

            bus.i_abort = (k == abort_at);
            if (k == spur_at) begin
                bus.i_start   = 1'b1;
                bus.i_num_vec = VEC_W'($urandom_range(0, 5));
                bus.i_reuse_w = 1'($urandom_range(0, 1));
            end
            @(negedge i_clk);
            bus.i_start = 1'b0;
            bus.i_abort = 1'b0;
        end

        if (!did_rst) begin
            if (load && (abort_at == 0 || abort_at > L)) wv_m = 1'b1;
            else if (load) wv_m = 1'b0;
            cur_k = last + 1;
            check_idle("end", 1'b0);
`ifdef SYSCTRL_PERF_EN
            chk("perf", bus.o_perf_cycles, 32'(last));
`endif
        end
    endtask

    initial begin
        bus.i_start   = 1'b0;
        bus.i_reuse_w = 1'b0;
        bus.i_num_vec = '0;
        bus.i_abort   = 1'b0;
        #12;
        check_idle("reset", 1'b1);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        check_idle("post_reset", 1'b1);

        // Preload + 4 vectors, then reuse with 2 vectors.
        run_job(4, 1'b0, 0, 0, 0);
        run_job(2, 1'b1, 0, 0, 0);
        // From reset: reuse request ignored, empty job still preloads.
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        wv_m  = 1'b0;
        run_job(0, 1'b1, 0, 0, 0);
        // Reload aborted mid-preload, then a reuse request must preload again.
        run_job(4, 1'b0, 5, 0, 0);
        run_job(3, 1'b1, 0, 0, 0);
        // Spurious start during FEED, then reset during DRAIN.
        run_job(6, 1'b1, 0, 2, 0);
        run_job(3, 1'b1, 0, 0, 20);
        idle_cycles(2);
        // Long job, results overlap the feed phase.
        run_job(0, 1'b0, 0, 0, 0);
        run_job(1500, 1'b1, 0, 0, 0);

        for (int j = 0; j < 40; j++) begin
            int r, n;
            r = int'($urandom_range(0, 9));
            n = (r < 2) ? 0 : (r < 7) ? int'($urandom_range(1, 12)) : int'($urandom_range(30, 90));
            run_job(n, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? -1 : 0,
                    ($urandom_range(0, 2) == 0) ? -1 : 0, 0);
            idle_cycles(int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
Job sequencer for the ROWSxCOLS weight-stationary PE grid. On a start request it runs up to three phases in order:
- preload the weights row by row through the north edge, holding the grid select high;
- stream activation vectors into the west edge;
- time the valid window in which south-edge results are captured.

It drives the weight/activation buffer read ports, the grid select line, and the result-capture strobes. It sits between the host command interface and the grid.

Parameters:
ROWS, 9, grid rows (weight rows to preload)
COLS, 32, grid columns
VEC_W, 16, width of vector count and activation address
RES_LAT, ROWS+COLS-1, cycles from first activation read to first valid south-edge result (covers buffer read plus skew)

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  asynchronous active-high reset
i_start  in  1  job request; sampled only in IDLE
i_reuse_w  in  1  with i_start: skip weight preload if weights are valid
i_num_vec  in  VEC_W  activation vectors in job; sampled with i_start
i_abort  in  1  synchronous abort of running job
o_busy  out  1  high in any state except IDLE
o_done  out  1  one-cycle pulse at normal job completion
o_wt_rd_en  out  1  weight buffer read enable
o_wt_addr  out  $clog2(ROWS)  weight row address
o_grid_sel  out  1  grid select: 1 = weight shift/load, 0 = compute
o_act_rd_en  out  1  activation buffer read enable
o_act_addr  out  VEC_W  activation vector address
o_res_valid  out  1  south-edge result row valid this cycle
o_res_idx  out  VEC_W  index of the vector whose result is valid
o_w_valid  out  1  grid holds a complete weight set

Behaviour:
- Reset (async): state IDLE; all outputs 0; internal counters 0; o_w_valid cleared.
- States: IDLE, LOAD_W, FEED, DRAIN, DONE.
- Job accept: IDLE and i_start=1 on edge t0. Latch N=i_num_vec.
  - Go to LOAD_W, unless i_reuse_w=1 and o_w_valid=1, in which case go to FEED.
  - If N=0 and preload is skipped, go straight to DONE.
- i_start outside IDLE is ignored (no queueing).
- LOAD_W lasts ROWS+1 cycles, t0+1 .. t0+ROWS+1:
  - o_wt_rd_en=1 for the first ROWS cycles, o_wt_addr = ROWS-1 down to 0 (bottom row first, since rows shift south).
  - o_grid_sel = o_wt_rd_en delayed 1 cycle, so it is high cycles t0+2 .. t0+ROWS+1 and aligned with the 1-cycle buffer latency.
  - On exit, set o_w_valid=1.
  - Next state: FEED, or DONE if N=0.
- FEED lasts N cycles:
  - o_act_rd_en=1, o_act_addr = 0..N-1 incrementing by 1.
  - o_grid_sel=0.
  - Then DRAIN.
- Result window:
  - Let f = first FEED cycle. o_res_valid=1 for exactly N consecutive cycles, f+RES_LAT .. f+RES_LAT+N-1.
  - o_res_idx = 0..N-1 during the window; it holds its last value otherwise.
  - The window counter runs across FEED and DRAIN.
  - DRAIN exits after the cycle carrying the last valid result.
- DONE: one cycle with o_done=1, o_busy=1; then IDLE.
- o_busy drops in the cycle after DONE.
- Abort: i_abort=1 in any non-IDLE state → IDLE on the next edge.
  - All enables and o_res_valid deassert; no o_done.
  - Abort during LOAD_W clears o_w_valid.
  - Abort in IDLE has no effect.
- Simultaneous i_start and i_abort in IDLE: start wins.
- Counters:
  - N up to 2^VEC_W-1 must work; there is no wrap inside a job.
  - o_act_addr of the final vector = N-1.
  - Drain counter width ≥ $clog2(RES_LAT+1).
- o_grid_sel is registered and glitch-free; 0 in every state except the LOAD_W data cycles.

Optional Feature:
SYSCTRL_PERF_EN
- Defined: adds output o_perf_cycles (32 bits).
  - Counts cycles with o_busy=1 in the current job; cleared on job accept.
  - Frozen at completion or abort; saturates at 2^32-1; reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. Defaults, i_start with N=4, reuse=0 at t0 → o_wt_addr 8..0 on t0+1..t0+9; o_grid_sel high t0+2..t0+10; o_act_addr 0..3 on t0+11..t0+14; o_res_valid t0+51..t0+54 with idx 0..3; o_done at t0+55; o_w_valid=1.
2. After test 1, start N=2, reuse=1 at t0 → no wt reads, o_grid_sel stays 0; act reads t0+1..t0+2; o_res_valid t0+41..t0+42; o_done at t0+43.
3. From reset, start N=0, reuse=1 → reuse ignored (o_w_valid=0); 10-cycle LOAD_W; o_done at t0+11; no act reads, no o_res_valid.
4. i_abort at t0+5 during LOAD_W → IDLE next cycle; o_busy=0, o_w_valid=0, no o_done; next reuse=1 start still runs LOAD_W.
5. i_start pulsed during FEED → ignored, job timing unchanged; i_rst asserted mid-DRAIN → all outputs 0 immediately, o_w_valid=0.
6. With SYSCTRL_PERF_EN, test 1 → o_perf_cycles=55 after o_done; with reuse N=2 → 43.
